uart_rx_param: RTL and testbench

- Parametrised UART receiver; successor to the fixed 8N1 receiver inside top_level.
- Configurable data width, parity, stop bits and oversampling, with an internal baud tick generator.
- Filters each bit with a 3-sample majority vote, flags framing, parity, break and overrun conditions, and presents each word on a valid/ready handshake.
- Sits between the board rx pin and the command/display logic.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_baud_gen.sv | 20 ++
 rtl/uart_rx_param.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and divider helper for the parametrised UART receiver
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} rx_state_t;
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversampling tick generator, one clk pulse every DIV clks
// ports: clk, reset (async active-low), clr (sync restart at 0), tick (out)
module uart_baud_gen #(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1)) && !clr;
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority-vote sampling and valid/ready output
// ports: clk, reset (async active-low), rx (serial in), rx_ready (consumer accept),
//        rx_data/rx_valid (held word), frame_err/parity_err/break_det (word status), overrun (drop pulse)
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 overrun
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam parity_t PT = parity_t'(PARITY);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
  if (DIV < 1 || OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0) begin : g_bad_cfg
    $error("uart_rx_param: DIV must be >= 1 and OVERSAMPLE even and >= 8");
  end
  logic sync1_q, sync2_q;
  rx_state_t state_q, state_d;
  logic [SW-1:0] s_cnt_q, s_cnt_d;
  logic [NW-1:0] n_q, n_d;
  logic [1:0] smp_q, smp_d;
  logic bit_q, bit_d, pbit_q, pbit_d, stop0_q, stop0_d;
  logic ferr_q, ferr_d, perr_q, perr_d, arm_q, arm_d, cmt_q, cmt_d;
  logic [DATA_BITS-1:0] data_q, data_d, rdata_q, rdata_d;
  logic rvalid_q, rvalid_d, oferr_q, oferr_d, operr_q, operr_d, obrk_q, obrk_d, ovr_q, ovr_d;
  logic tick, maj, bit_end, brk, load;
  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q == IDLE),
    .tick (tick)
  );
  // arm_q blocks a new start until the line has been seen high, so a held-low
  // line after a break yields exactly one word
  always_comb begin
    maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);
    bit_end = tick && s_cnt_q == S_END;
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_d     = n_q;
    smp_d   = smp_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pbit_d  = pbit_q;
    stop0_d = stop0_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    cmt_d   = 1'b0;
    arm_d   = (state_q == IDLE && sync2_q) ? 1'b1 : arm_q;
    if (tick) begin
      s_cnt_d = bit_end ? '0 : s_cnt_q + 1'b1;
      if (s_cnt_q == S_LO) smp_d[0] = sync2_q;
      if (s_cnt_q == S_MID) smp_d[1] = sync2_q;
      if (s_cnt_q == S_HI) bit_d = maj;
    end
    case (state_q)
      IDLE: begin
        s_cnt_d = '0;
        n_d     = '0;
        if (arm_q && !sync2_q) begin
          state_d = START;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end
      START: if (bit_end) state_d = bit_q ? IDLE : DATA;
      DATA: if (bit_end) begin
        data_d = {bit_q, data_q[DATA_BITS-1:1]};
        n_d    = n_q + 1'b1;
        if (n_q == N_LAST) begin
          n_d     = '0;
          state_d = (PT == PAR_NONE) ? STOP : PAR;
        end
      end
      PAR: if (bit_end) begin
        pbit_d  = bit_q;
        perr_d  = bit_q != (^data_q ^ (PT == PAR_ODD));
        state_d = STOP;
      end
      STOP: begin
        if (STOP_BITS == 2 && n_q == '0) begin
          if (bit_end) begin
            stop0_d = bit_q;
            ferr_d  = !bit_q;
            n_d     = NW'(1);
          end
        end else if (tick && s_cnt_q == S_HI) begin
          // last stop bit commits at its third sample to catch an immediate next start
          ferr_d  = ferr_q | !maj;
          stop0_d = (STOP_BITS == 1) ? maj : stop0_q;
          arm_d   = maj;
          cmt_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    brk      = data_q == '0 && (PT == PAR_NONE || !pbit_q) && !stop0_q;
    load     = cmt_q && (!rvalid_q || rx_ready);
    rdata_d  = load ? data_q : rdata_q;
    oferr_d  = load ? ferr_q : oferr_q;
    operr_d  = load ? perr_q : operr_q;
    obrk_d   = load ? brk : obrk_q;
    rvalid_d = load | (rvalid_q & !rx_ready);
    ovr_d    = cmt_q & !load;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= IDLE;
      s_cnt_q  <= '0;
      n_q      <= '0;
      smp_q    <= '0;
      bit_q    <= 1'b0;
      data_q   <= '0;
      pbit_q   <= 1'b0;
      stop0_q  <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      arm_q    <= 1'b0;
      cmt_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      oferr_q  <= 1'b0;
      operr_q  <= 1'b0;
      obrk_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync1_q  <= rx;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      s_cnt_q  <= s_cnt_d;
      n_q      <= n_d;
      smp_q    <= smp_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      pbit_q   <= pbit_d;
      stop0_q  <= stop0_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
      arm_q    <= arm_d;
      cmt_q    <= cmt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      oferr_q  <= oferr_d;
      operr_q  <= operr_d;
      obrk_q   <= obrk_d;
      ovr_q    <= ovr_d;
    end
  assign rx_data    = rdata_q;
  assign rx_valid   = rvalid_q;
  assign frame_err  = oferr_q;
  assign parity_err = operr_q;
  assign break_det  = obrk_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and random frames on an 8N1 and an 8E1 receiver against a frame-level model
module tb_uart_rx_param;
  localparam int DIV = 8;
  localparam int OS = 16;
  localparam int BIT = DIV * OS;
  localparam int CLKF = 12000000;
  localparam int BAUD = CLKF / (DIV * OS);
  logic clk = 1'b0, reset = 1'b0, rx0 = 1'b1, rx1 = 1'b1, rx_ready = 1'b0;
  logic [7:0] d0, d1;
  logic v0, v1, fe0, fe1, pe0, pe1, bk0, bk1, ov0, ov1;
  int tests = 0, fails = 0, rise_at, ovr_cnt;
  always #5 clk = ~clk;
  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .rx(rx0), .rx_ready(rx_ready), .rx_data(d0), .rx_valid(v0),
    .frame_err(fe0), .parity_err(pe0), .break_det(bk0), .overrun(ov0));
  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .rx_ready(rx_ready), .rx_data(d1), .rx_valid(v1),
    .frame_err(fe1), .parity_err(pe1), .break_det(bk1), .overrun(ov1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx0 = v; else rx1 = v;
  endtask
  // line-level frame: start, LSB-first data, optional parity, one stop bit, then line left at 'after'
  task automatic send(input int sel, input logic [7:0] d, input bit hp, input logic pb, input logic st, input logic after);
    logic [10:0] bits;
    int nb;
    logic pv;
    bits = hp ? {st, pb, d, 1'b0} : {1'b1, st, d, 1'b0};
    nb = hp ? 11 : 10;
    rise_at = -1;
    ovr_cnt = 0;
    pv = sel ? v1 : v0;
    for (int i = 0; i < nb; i++) begin
      drive(sel, bits[i]);
      for (int c = 0; c < BIT; c++) begin
        @(negedge clk);
        if ((sel ? v1 : v0) && !pv && rise_at < 0 && i == nb - 1) rise_at = c + 1;
        pv = sel ? v1 : v0;
        ovr_cnt += int'(sel ? ov1 : ov0);
      end
    end
    drive(sel, after);
    repeat (2 * DIV) @(negedge clk);
  endtask
  task automatic accept();
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
  endtask
  task automatic check_word(input string tag, input int sel, input logic [7:0] d, input bit hp, input logic pb, input logic st);
    logic fe, pe, bk;
    fe = !st;
    pe = hp && (pb != ^d);
    bk = d == 8'h00 && (!hp || !pb) && !st;
    chk({tag, "_valid"}, sel ? v1 : v0, 1);
    chk({tag, "_data"}, sel ? d1 : d0, d);
    chk({tag, "_frame_err"}, sel ? fe1 : fe0, fe);
    chk({tag, "_parity_err"}, sel ? pe1 : pe0, pe);
    chk({tag, "_break"}, sel ? bk1 : bk0, bk);
  endtask
  initial begin
    logic [7:0] rd;
    logic rs, rp;
    repeat (4) @(negedge clk);
    chk("reset_valid", v0, 0);
    chk("reset_data", d0, 0);
    chk("reset_flags", {fe0, pe0, bk0, ov0}, 0);
    reset = 1'b1;
    repeat (BIT) @(negedge clk);
    send(0, 8'h64, 0, 0, 1, 1);
    check_word("8n1_64", 0, 8'h64, 0, 0, 1);
    chk("latency_window", rise_at >= (OS / 2) * DIV && rise_at <= (OS / 2 + 2) * DIV + 5, 1);
    accept();
    chk("accept_clears_valid", v0, 0);
    send(0, 8'h66, 0, 0, 0, 1);
    check_word("stop0_66", 0, 8'h66, 0, 0, 0);
    accept();
    send(1, 8'h64, 1, 1, 1, 1);
    check_word("even_ok", 1, 8'h64, 1, 1, 1);
    accept();
    send(1, 8'h64, 1, 0, 1, 1);
    check_word("even_bad", 1, 8'h64, 1, 0, 1);
    accept();
    rx0 = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rx0 = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("glitch_no_valid", v0, 0);
    send(0, 8'hA5, 0, 0, 1, 1);
    check_word("after_glitch", 0, 8'hA5, 0, 0, 1);
    accept();
    send(0, 8'h64, 0, 0, 1, 1);
    chk("first_no_overrun", ovr_cnt, 0);
    send(0, 8'h66, 0, 0, 1, 1);
    chk("overrun_one_clk", ovr_cnt, 1);
    check_word("held_64", 0, 8'h64, 0, 0, 1);
    accept();
    chk("valid_cleared_after_overrun", v0, 0);
    send(0, 8'h5A, 0, 0, 1, 1);
    rd = 8'h3C;
    rx0 = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx0 = rd[i];
      repeat (BIT) @(negedge clk);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset_valid", v0, 0);
    chk("midreset_data", d0, 0);
    chk("midreset_flags", {fe0, pe0, bk0, ov0}, 0);
    rx0 = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send(0, 8'hA5, 0, 0, 1, 1);
    check_word("post_reset_a5", 0, 8'hA5, 0, 0, 1);
    accept();
    send(0, 8'h00, 0, 0, 0, 0);
    check_word("break", 0, 8'h00, 0, 0, 0);
    accept();
    ovr_cnt = 0;
    for (int c = 0; c < 20 * BIT; c++) begin
      @(negedge clk);
      ovr_cnt += int'(v0);
    end
    chk("held_low_no_repeat", ovr_cnt, 0);
    rx0 = 1'b1;
    repeat (BIT) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      rd = 8'($urandom);
      rs = $urandom_range(0, 3) != 0;
      rp = 1'($urandom);
      send(0, rd, 0, 0, rs, 1);
      check_word("rand_8n1", 0, rd, 0, 0, rs);
      accept();
      send(1, rd, 1, rp, rs, 1);
      check_word("rand_8e1", 1, rd, 1, rp, rs);
      accept();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
